// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM state encoding and
// the bit positions of the instruction fields.
package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_LOAD_A    = 3'd3,
        S_LOAD_B    = 3'd4,
        S_EXECUTE   = 3'd5,
        S_WRITEBACK = 3'd6
    } state_t;

    // Instruction layout, LSB first: opcode(3) | op1(aw) | op2(aw) | res(aw)
    function automatic int op1_lsb(input int aw);
        return 3 + 0 * aw;
    endfunction

    function automatic int op2_lsb(input int aw);
        return 3 + aw;
    endfunction

    function automatic int res_lsb(input int aw);
        return 3 + 2 * aw;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU. carry is the carry-out for ADD, the borrow for SUB and the
// shifted-out MSB for SHL; zero for every other opcode, including HALT.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero
);

    logic [DATA_WIDTH:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_WIDTH-1:0];
                carry  = wide[DATA_WIDTH];
            end
            OP_SUB: begin
                // Top bit of the zero-extended difference is set exactly when a < b.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_WIDTH-1:0];
                carry  = wide[DATA_WIDTH];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_WIDTH-2:0], 1'b0};
                carry  = a[DATA_WIDTH-1];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle register-to-register CPU: host loads instruction/data memories while
// idle, pulses start, and reads results through the combinational debug port.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for start; host memory writes accepted
// S_FETCH     | ir <= imem[pc]
// S_DECODE    | HALT ends the run with done, otherwise continue to operand load
// S_LOAD_A    | a_q <= dmem[op1]
// S_LOAD_B    | b_q <= dmem[op2]
// S_EXECUTE   | r_q <= ALU(a_q, b_q), flags update
// S_WRITEBACK | dmem[res] <= r_q; last instruction ends the run, else pc+1
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH),
    parameter int INSTR_W    = 3 + 3 * AW
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AW:0]           prog_len,
    input  logic                  imem_we,
    input  logic [AW-1:0]         imem_addr,
    input  logic [INSTR_W-1:0]    imem_wdata,
    input  logic                  dmem_we,
    input  logic [AW-1:0]         dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         pc,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    localparam int OP1_LSB = op1_lsb(AW);
    localparam int OP2_LSB = op2_lsb(AW);
    localparam int RES_LSB = res_lsb(AW);

    state_t                state;
    logic [INSTR_W-1:0]    ir;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] r_q;
    logic [AW:0]           len_q;

    logic [INSTR_W-1:0]    imem [DEPTH];
    logic [DATA_WIDTH-1:0] dmem [DEPTH];

    logic [2:0]            opcode;
    logic [AW-1:0]         op1_addr;
    logic [AW-1:0]         op2_addr;
    logic [AW-1:0]         res_addr;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  alu_zero;
    logic                  last_instr;

    assign opcode     = ir[2:0];
    assign op1_addr   = ir[OP1_LSB +: AW];
    assign op2_addr   = ir[OP2_LSB +: AW];
    assign res_addr   = ir[RES_LSB +: AW];
    assign last_instr = ({1'b0, pc} == (len_q - {{AW{1'b0}}, 1'b1}));
    assign busy       = (state != S_IDLE);
    assign dbg_rdata  = dmem[dbg_addr];

    cpu_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op    (opcode),
        .a     (a_q),
        .b     (b_q),
        .result(alu_result),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Memories are never reset so their contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && imem_we)
            imem[imem_addr] <= imem_wdata;
        if (state == S_WRITEBACK)
            dmem[res_addr] <= r_q;
        else if (state == S_IDLE && dmem_we)
            dmem[dmem_addr] <= dmem_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            pc         <= '0;
            done       <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            len_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len != '0) begin
                            pc    <= '0;
                            len_q <= prog_len;
                            state <= S_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    a_q   <= dmem[op1_addr];
                    state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    b_q   <= dmem[op2_addr];
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_q        <= alu_result;
                    zero_flag  <= alu_zero;
                    carry_flag <= alu_carry;
                    state      <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (last_instr) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        pc    <= pc + AW'(1);
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: each start pushes the reference model's
// expected latency, flags, pc and memory image; a monitor checks them on done.
module tb_multi_cycle_cpu;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int IW    = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_addr = '0;
    logic [IW-1:0] imem_wdata = '0;
    logic          dmem_we = 1'b0;
    logic [AW-1:0] dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_rdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic          zero_flag;
    logic          carry_flag;

    multi_cycle_cpu #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .prog_len  (prog_len),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                         start_cyc;
        int                         lat;
        logic [AW-1:0]              pc;
        logic                       z;
        logic                       c;
        logic [DEPTH-1:0][DW-1:0]   mem;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: architectural state only, no notion of FSM states.
    logic [IW-1:0] imem_m [DEPTH];
    logic [DW-1:0] dmem_m [DEPTH];
    logic          zf_m = 1'b0;
    logic          cf_m = 1'b0;
    logic [AW-1:0] pc_m = '0;

    task automatic model_step(input logic [IW-1:0] ins, output bit halted);
        int op, o1, o2, rd, a, b, r;
        bit c;
        op = int'(ins[2:0]);
        o1 = int'(ins[5:3]);
        o2 = int'(ins[8:6]);
        rd = int'(ins[11:9]);
        a = int'(dmem_m[o1]);
        b = int'(dmem_m[o2]);
        r = 0;
        c = 1'b0;
        halted = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b); if (r < 0) r = r + 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = 2 * a; c = (a >= 128); end
            default: halted = 1'b1;
        endcase
        if (!halted) begin
            r = r % 256;
            dmem_m[rd] = 8'(r);
            zf_m = (r == 0);
            cf_m = c;
        end
    endtask

    task automatic model_run(input int len, output exp_t e);
        bit h;
        e.start_cyc = 0;
        e.lat = 1;
        for (int i = 0; i < len; i++) begin
            model_step(imem_m[i], h);
            pc_m = AW'(i);
            if (h) begin
                e.lat += 2;
                break;
            end
            e.lat += 6;
        end
        e.pc = pc_m;
        e.z  = zf_m;
        e.c  = cf_m;
        for (int i = 0; i < DEPTH; i++) e.mem[i] = dmem_m[i];
    endtask

    function automatic logic [IW-1:0] ins(input int op, input int o1, input int o2, input int rd);
        return {3'(rd), 3'(o2), 3'(o1), 3'(op)};
    endfunction

    // Monitor: consumes one expectation per done pulse.
    int done_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen at cycle %0d, no run pending", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("pc", 32'(pc), 32'(e.pc));
                    chk("zero_flag", 32'(zero_flag), 32'(e.z));
                    chk("carry_flag", 32'(carry_flag), 32'(e.c));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    for (int i = 0; i < DEPTH; i++) begin
                        dbg_addr = AW'(i);
                        #1;
                        chk($sformatf("dmem[%0d]", i), 32'(dbg_rdata), 32'(e.mem[i]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_imem(input int a, input logic [IW-1:0] d);
        imem_we = 1'b1; imem_addr = AW'(a); imem_wdata = d;
        imem_m[a] = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic wr_dmem(input int a, input logic [DW-1:0] d);
        dmem_we = 1'b1; dmem_addr = AW'(a); dmem_wdata = d;
        dmem_m[a] = d;
        tick();
        dmem_we = 1'b0;
    endtask

    task automatic issue(input int len);
        exp_t e;
        model_run(len, e);
        e.start_cyc = cyc;
        sb_q.push_back(e);
        start = 1'b1;
        prog_len = (AW+1)'(len);
        tick();
        start = 1'b0;
    endtask

    int busy_hi = 0;
    task automatic wait_done(input int budget);
        int seen, n;
        seen = done_cnt;
        n = 0;
        while (done_cnt == seen && n < budget) begin
            tick();
            if (busy) busy_hi++;
            n++;
        end
        if (done_cnt == seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
        tick();
    endtask

    function automatic int rand_op_nohalt();
        return int'($urandom_range(0, 6));
    endfunction

    function automatic logic [IW-1:0] rand_ins(input bit allow_halt);
        int op;
        op = allow_halt ? int'($urandom_range(0, 7)) : rand_op_nohalt();
        return ins(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endfunction

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_dmem(i, 8'($urandom));
            wr_imem(i, ins(7, 0, 0, 0));
        end

        // ADD r2 = r0 + r1
        wr_dmem(0, 8'd5); wr_dmem(1, 8'd7);
        wr_imem(0, 12'b010_001_000_000);
        issue(1); wait_done(50);

        // SUB with borrow, then NOT of the result
        wr_dmem(0, 8'd3); wr_dmem(1, 8'd5);
        wr_imem(0, ins(1, 0, 1, 2));
        wr_imem(1, ins(5, 2, 0, 3));
        issue(2); wait_done(50);

        // SHL out of the MSB, then ADD of zeros; res aliases op1
        wr_dmem(0, 8'h80);
        wr_imem(0, ins(6, 0, 0, 0));
        wr_imem(1, ins(0, 0, 0, 1));
        issue(2); wait_done(50);

        // 8-instruction program with HALT at slot 3
        for (int i = 0; i < DEPTH; i++) wr_imem(i, rand_ins(1'b0));
        wr_imem(3, ins(7, 0, 0, 0));
        issue(8); wait_done(100);

        // Zero-length program: immediate done, never busy
        busy_hi = 0;
        issue(0); wait_done(10);
        chk("len0_busy_cycles", 32'(busy_hi), 32'd0);

        // start / memory writes while busy are dropped
        for (int i = 0; i < DEPTH; i++) wr_imem(i, rand_ins(1'b0));
        issue(8);
        repeat (3) tick();
        start = 1'b1; prog_len = 4'd1;
        dmem_we = 1'b1; dmem_addr = 3'd5; dmem_wdata = ~dmem_m[5];
        imem_we = 1'b1; imem_addr = 3'd7; imem_wdata = ins(7, 0, 0, 0);
        tick();
        start = 1'b0; dmem_we = 1'b0; imem_we = 1'b0;
        wait_done(100);

        // Host dmem write in the same cycle as start
        wr_imem(0, ins(0, 0, 0, 1));
        dmem_we = 1'b1; dmem_addr = 3'd0; dmem_wdata = 8'h11;
        dmem_m[0] = 8'h11;
        issue(1);
        dmem_we = 1'b0;
        wait_done(50);

        // Reset during EXECUTE of instruction 1
        wr_imem(0, ins(0, 0, 1, 2));
        wr_imem(1, ins(4, 2, 0, 3));
        model_step(imem_m[0], h);
        start = 1'b1; prog_len = 4'd2;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_zero", 32'(zero_flag), 32'd0);
        chk("midrst_carry", 32'(carry_flag), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        zf_m = 1'b0; cf_m = 1'b0; pc_m = '0;
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk($sformatf("midrst_dmem[%0d]", i), 32'(dbg_rdata), 32'(dmem_m[i]));
        end
        issue(2); wait_done(50);

        // Randomized programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr_dmem(i, 8'($urandom));
                wr_imem(i, rand_ins(1'b1));
            end
            issue(int'($urandom_range(0, 8)));
            wait_done(100);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
